// File: rtl/jedro_1_arb_pkg.sv
// jedro_1 memory arbiter: shared types and constants.
// Owner tags, priority states and grant vector bit positions.
package jedro_1_arb_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int BE_WIDTH   = DATA_WIDTH/8;

   // Bit positions inside the one-hot grant vector
   localparam int GNT_IF = 0;
   localparam int GNT_D  = 1;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_IF,
      OWN_DATA
   } owner_e;

   typedef enum logic {
      DATA_PRIO,
      FETCH_PRIO
   } prio_e;

   function automatic owner_e owner_of(input logic [1:0] gnt);
      owner_e o;
      o = OWN_NONE;
      unique case (1'b1)
         gnt[GNT_D]:  o = OWN_DATA;
         gnt[GNT_IF]: o = OWN_IF;
         default:     o = OWN_NONE;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/jedro_1_arb_prio.sv
// jedro_1 memory arbiter: priority FSM with bounded data streak.
// Ports: clk_i, rstn_i, if_req_i, d_req_i in; gnt_o one-hot {data, fetch} out.
module jedro_1_arb_prio
   import jedro_1_arb_pkg::*;
#(
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic       clk_i,
   input  logic       rstn_i,
   input  logic       if_req_i,
   input  logic       d_req_i,
   output logic [1:0] gnt_o
);

   localparam int CW = $clog2(MAX_DATA_STREAK+1);
   localparam logic [CW-1:0] MAX_C  = CW'(MAX_DATA_STREAK);
   localparam logic [CW-1:0] LAST_C = CW'(MAX_DATA_STREAK-1);

   prio_e         state_q;
   prio_e         state_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= DATA_PRIO;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      gnt_o   = 2'b00;
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         DATA_PRIO: begin
            if (d_req_i) begin
               gnt_o[GNT_D] = 1'b1;
               if (if_req_i) begin
                  // Fetch is being starved: after the last allowed
                  // data win, hand the next slot to fetch.
                  if (cnt_q == LAST_C) begin
                     cnt_d   = MAX_C;
                     state_d = FETCH_PRIO;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end else if (if_req_i) begin
               gnt_o[GNT_IF] = 1'b1;
               cnt_d         = '0;
            end else begin
               cnt_d = '0;
            end
         end
         FETCH_PRIO: begin
            // Owed slot is spent either way; a withdrawn fetch
            // simply forfeits it.
            state_d = DATA_PRIO;
            cnt_d   = '0;
            if (if_req_i) begin
               gnt_o[GNT_IF] = 1'b1;
            end else if (d_req_i) begin
               gnt_o[GNT_D] = 1'b1;
            end
         end
         default: begin
            state_d = DATA_PRIO;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: rtl/jedro_1_mem_arbiter.sv
// jedro_1 memory arbiter: shares one 1-cycle-latency RAM between fetch and data.
// Ports: if_* fetch master, d_* data master, mem_* RAM side, clk_i/rstn_i.
module jedro_1_mem_arbiter #(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic                    if_req_i,
   input  logic [ADDR_WIDTH-1:0]   if_addr_i,
   output logic                    if_gnt_o,
   output logic                    if_rvalid_o,
   output logic [DATA_WIDTH-1:0]   if_rdata_o,
   input  logic                    d_req_i,
   input  logic                    d_we_i,
   input  logic [DATA_WIDTH/8-1:0] d_be_i,
   input  logic [ADDR_WIDTH-1:0]   d_addr_i,
   input  logic [DATA_WIDTH-1:0]   d_wdata_i,
   output logic                    d_gnt_o,
   output logic                    d_rvalid_o,
   output logic [DATA_WIDTH-1:0]   d_rdata_o,
   output logic                    mem_en_o,
   output logic [DATA_WIDTH/8-1:0] mem_we_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

   import jedro_1_arb_pkg::*;

   logic [1:0] gnt;
   logic       if_req_ok;
   logic       d_req_ok;
   owner_e     owner_q;
   owner_e     owner_d;
   logic       wr_q;
   logic       wr_d;

   // No grant may leave the block while reset is held
   assign if_req_ok = if_req_i & rstn_i;
   assign d_req_ok  = d_req_i & rstn_i;

   jedro_1_arb_prio #(
      .MAX_DATA_STREAK (MAX_DATA_STREAK)
   ) u_prio (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .if_req_i (if_req_ok),
      .d_req_i  (d_req_ok),
      .gnt_o    (gnt)
   );

   assign if_gnt_o = gnt[GNT_IF];
   assign d_gnt_o  = gnt[GNT_D];

   always_comb begin
      mem_en_o    = if_gnt_o | d_gnt_o;
      mem_addr_o  = d_gnt_o ? d_addr_i : if_addr_i;
      mem_wdata_o = d_wdata_i;
      mem_we_o    = '0;
      if (d_gnt_o && d_we_i) begin
         mem_we_o = d_be_i;
      end
   end

   assign owner_d = owner_of(gnt);
   assign wr_d    = d_gnt_o & d_we_i;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         owner_q <= OWN_NONE;
         wr_q    <= 1'b0;
      end else begin
         owner_q <= owner_d;
         wr_q    <= wr_d;
      end
   end

   always_comb begin
      if_rvalid_o = (owner_q == OWN_IF);
      d_rvalid_o  = (owner_q == OWN_DATA);
      if_rdata_o  = '0;
      d_rdata_o   = '0;
      if (if_rvalid_o) begin
         if_rdata_o = mem_rdata_i;
      end
      // Write acks carry no data
      if (d_rvalid_o && !wr_q) begin
         d_rdata_o = mem_rdata_i;
      end
   end

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Self-checking bench for jedro_1_mem_arbiter.
// Behavioural model + directed vectors with literal expectations.
module tb_jedro_1_mem_arbiter;

   import jedro_1_arb_pkg::*;

   localparam int MAXS = 4;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [3:0]  d_be = '0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;

   int checks = 0;
   int failures = 0;
   int pulses = 0;

   always #5 clk = ~clk;

   jedro_1_mem_arbiter #(
      .DATA_WIDTH      (32),
      .ADDR_WIDTH      (32),
      .MAX_DATA_STREAK (MAXS)
   ) dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .if_req_i    (if_req),
      .if_addr_i   (if_addr),
      .if_gnt_o    (if_gnt),
      .if_rvalid_o (if_rvalid),
      .if_rdata_o  (if_rdata),
      .d_req_i     (d_req),
      .d_we_i      (d_we),
      .d_be_i      (d_be),
      .d_addr_i    (d_addr),
      .d_wdata_i   (d_wdata),
      .d_gnt_o     (d_gnt),
      .d_rvalid_o  (d_rvalid),
      .d_rdata_o   (d_rdata),
      .mem_en_o    (mem_en),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata)
   );

   // Single-port RAM, 1-cycle read latency, byte writes
   logic [31:0] ram [0:1023];
   always @(posedge clk) begin
      if (mem_en) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_we[b]) ram[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
         mem_rdata <= ram[mem_addr[11:2]];
      end
   end

   always @(posedge d_rvalid) pulses++;

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b, want %b at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // streak = data wins in a row while fetch also waited
   int          streak = 0;
   bit          pend_v = 0;
   bit          pend_f = 0;
   logic [31:0] pend_data = '0;
   logic [31:0] shadow [0:1023];

   always @(negedge clk) begin
      bit eg_f;
      bit eg_d;
      bit owed;
      if (!rstn) begin
         chk1("rst_if_gnt", if_gnt, 1'b0);
         chk1("rst_d_gnt", d_gnt, 1'b0);
         chk1("rst_if_rvalid", if_rvalid, 1'b0);
         chk1("rst_d_rvalid", d_rvalid, 1'b0);
         chk1("rst_mem_en", mem_en, 1'b0);
         chk32("rst_mem_we", 32'(mem_we), 32'd0);
         chk32("rst_if_rdata", if_rdata, 32'd0);
         chk32("rst_d_rdata", d_rdata, 32'd0);
         streak = 0;
         pend_v = 0;
      end else begin
         chk1("m_if_rvalid", if_rvalid, pend_v && pend_f);
         chk1("m_d_rvalid", d_rvalid, pend_v && !pend_f);
         chk32("m_if_rdata", if_rdata, (pend_v && pend_f) ? pend_data : 32'd0);
         chk32("m_d_rdata", d_rdata, (pend_v && !pend_f) ? pend_data : 32'd0);
         owed = (streak >= MAXS);
         eg_f = if_req && (owed || !d_req);
         eg_d = d_req && !eg_f;
         chk1("m_if_gnt", if_gnt, eg_f);
         chk1("m_d_gnt", d_gnt, eg_d);
         chk1("m_mem_en", mem_en, eg_f || eg_d);
         chk32("m_mem_we", 32'(mem_we), (eg_d && d_we) ? 32'(d_be) : 32'd0);
         if (eg_f) chk32("m_mem_addr", mem_addr, if_addr);
         if (eg_d) chk32("m_mem_addr", mem_addr, d_addr);
         if (eg_d && d_we) chk32("m_mem_wdata", mem_wdata, d_wdata);
         pend_v = eg_f || eg_d;
         pend_f = eg_f;
         if (eg_f) pend_data = shadow[if_addr[11:2]];
         else if (eg_d && !d_we) pend_data = shadow[d_addr[11:2]];
         else pend_data = 32'd0;
         if (eg_d && d_we) begin
            for (int b = 0; b < 4; b++)
               if (d_be[b]) shadow[d_addr[11:2]][8*b +: 8] = d_wdata[8*b +: 8];
         end
         if (eg_f || (!if_req && !d_req) || owed) streak = 0;
         else if (if_req && d_req) streak++;
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      if_req = 0;
      d_req = 0;
      d_we = 0;
      d_be = '0;
   endtask

   task automatic dwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      d_req = 1;
      d_we = 1;
      d_addr = a;
      d_wdata = d;
      d_be = be;
      @(negedge clk);
      chk1("wr_gnt", d_gnt, 1'b1);
      nxt();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] fw [3];
      logic [31:0] t2d [2];
      logic [3:0]  t2b [2];
      logic [31:0] t2e [2];
      string       pat;
      byte         got;
      int          base;
      fw[0] = 32'h00500313;
      fw[1] = 32'h41f36313;
      fw[2] = 32'h00000013;
      t2d[0] = 32'hDEADBEEF; t2b[0] = 4'b1111; t2e[0] = 32'hDEADBEEF;
      t2d[1] = 32'h000000AA; t2b[1] = 4'b0001; t2e[1] = 32'hDEADBEAA;
      pat = "DDDDFDDDDF";

      idle();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk1("reset_if_rvalid", if_rvalid, 1'b0);
      chk1("reset_d_rvalid", d_rvalid, 1'b0);
      chk1("reset_mem_en", mem_en, 1'b0);
      nxt();
      rstn = 1;
      chk32("reset_state", 32'(dut.u_prio.state_q), 32'(DATA_PRIO));
      chk32("reset_cnt", 32'(dut.u_prio.cnt_q), 32'd0);

      // preload program words through the data port
      for (int i = 0; i < 3; i++) dwrite(32'(4*i), fw[i], 4'hF);
      idle();
      nxt();

      // fetch only
      for (int i = 0; i < 5; i++) begin
         if_req = (i < 3);
         if_addr = 32'(4*i);
         @(negedge clk);
         chk1("t1_gnt", if_gnt, i < 3);
         chk1("t1_rvalid", if_rvalid, i >= 1 && i <= 3);
         if (i >= 1 && i <= 3) chk32("t1_rdata", if_rdata, fw[i-1]);
         chk1("t1_d_rvalid", d_rvalid, 1'b0);
         nxt();
      end
      idle();

      // data write then read
      for (int k = 0; k < 2; k++) begin
         dwrite(32'h100, t2d[k], t2b[k]);
         d_req = 1; d_we = 0; d_be = '0; d_addr = 32'h100;
         @(negedge clk);
         chk1("t2_rd_gnt", d_gnt, 1'b1);
         chk1("t2_wr_ack", d_rvalid, 1'b1);
         chk32("t2_wr_rdata", d_rdata, 32'd0);
         nxt();
         idle();
         @(negedge clk);
         chk1("t2_rd_rvalid", d_rvalid, 1'b1);
         chk32("t2_rd_rdata", d_rdata, t2e[k]);
         nxt();
      end

      // contention
      if_req = 1; if_addr = 32'h0;
      d_req = 1; d_we = 0; d_addr = 32'h100;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         got = if_gnt ? "F" : (d_gnt ? "D" : "-");
         chk32("t3_seq", 32'(got), 32'(pat[i]));
         chk1("t3_both", if_gnt & d_gnt, 1'b0);
         nxt();
      end
      idle();
      nxt();

      // mixed response routing
      if_req = 1; if_addr = 32'h4;
      @(negedge clk);
      chk1("t4_if_gnt", if_gnt, 1'b1);
      nxt();
      if_req = 0;
      d_req = 1; d_we = 0; d_addr = 32'h100;
      @(negedge clk);
      chk1("t4_d_gnt", d_gnt, 1'b1);
      chk1("t4_if_rvalid", if_rvalid, 1'b1);
      chk1("t4_d_rvalid0", d_rvalid, 1'b0);
      chk32("t4_if_rdata", if_rdata, 32'h41f36313);
      nxt();
      idle();
      @(negedge clk);
      chk1("t4_if_rvalid0", if_rvalid, 1'b0);
      chk1("t4_d_rvalid", d_rvalid, 1'b1);
      chk32("t4_d_rdata", d_rdata, 32'hDEADBEAA);
      nxt();

      // reset with a data read in flight
      d_req = 1; d_we = 0; d_addr = 32'h100;
      @(negedge clk);
      chk1("t5_gnt", d_gnt, 1'b1);
      base = pulses;
      #2;
      rstn = 0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      rstn = 1;
      @(negedge clk);
      chk1("t5_d_rvalid", d_rvalid, 1'b0);
      chk32("t5_d_rdata", d_rdata, 32'd0);
      chk32("t5_state", 32'(dut.u_prio.state_q), 32'(DATA_PRIO));
      chk32("t5_cnt", 32'(dut.u_prio.cnt_q), 32'd0);
      nxt();
      nxt();
      chk32("t5_no_pulse", 32'(pulses - base), 32'd0);

      // FETCH_PRIO with fetch withdrawn
      if_req = 1; if_addr = 32'h8;
      d_req = 1; d_we = 0; d_addr = 32'h0;
      for (int i = 0; i < MAXS; i++) begin
         @(negedge clk);
         chk1("t6_d_win", d_gnt, 1'b1);
         nxt();
      end
      if_req = 0;
      @(negedge clk);
      chk32("t6_fetch_prio", 32'(dut.u_prio.state_q), 32'(FETCH_PRIO));
      chk1("t6_d_gnt", d_gnt, 1'b1);
      chk1("t6_if_gnt", if_gnt, 1'b0);
      nxt();
      idle();
      chk32("t6_state", 32'(dut.u_prio.state_q), 32'(DATA_PRIO));
      chk32("t6_cnt", 32'(dut.u_prio.cnt_q), 32'd0);
      nxt();
      nxt();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
